rf_port_sequencer: RTL and testbench

//  Time-multiplexes the single-port 32x32 register file (one address, OE, Wr; write on negedge clk)

---
 rtl/rf_port_sequencer_pkg.sv | 20 ++
 rtl/rf_port_sequencer.sv | 152 +++++++++++++++
 tb/tb_rf_port_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_port_sequencer_pkg.sv
// Shared definitions for the register-file port sequencer: default widths
// and the 2-bit state encoding of the port-arbitration FSM.
package rf_port_sequencer_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RD_RS = 2'b01,
        ST_RD_RT = 2'b10,
        ST_WR    = 2'b11
    } seq_state_e;

    // True for the two states that drive OE on the register file
    function automatic logic is_read_state(input seq_state_e st);
        return (st == ST_RD_RS) || (st == ST_RD_RT);
    endfunction

endpackage

// File: rtl/rf_port_sequencer.sv
// Time-multiplexes a single-port register file between operand fetch
// (rs, optionally rt) and writeback. Every RF-facing output is a flop, so
// Reg/OE/Wr/W_data hold steady for a whole clock period and the RF can
// commit its write on the mid-cycle falling edge.
module rf_port_sequencer
    import rf_port_sequencer_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int WR_PRIORITY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic          rd_two,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_val,
    output logic [DW-1:0] rt_val,
    output logic          rd_valid,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_done,
    output logic          busy,
    output logic [AW-1:0] rf_reg,
    output logic          rf_oe,
    output logic          rf_wr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    localparam bit WR_FIRST = (WR_PRIORITY != 0);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] rf_reg_q, rf_reg_d;
    logic          rf_oe_q, rf_oe_d;
    logic          rf_wr_q, rf_wr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic [DW-1:0] rs_val_q, rs_val_d;
    logic [DW-1:0] rt_val_q, rt_val_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_done_q, wr_done_d;
    logic [AW-1:0] rt_addr_q, rt_addr_d;
    logic          two_q, two_d;

    // A request is ignored in its own done cycle: the requester is still
    // dropping it, and re-accepting would start a duplicate operation.
    logic rd_ok, wr_ok, take_wr, take_rd;
    assign rd_ok   = rd_req && !rd_valid_q;
    assign wr_ok   = wr_req && !wr_done_q;
    assign take_wr = wr_ok && (WR_FIRST || !rd_ok);
    assign take_rd = rd_ok && !take_wr;

    // Next-state and next-output logic for the arbitration FSM
    always_comb begin
        state_d    = state_q;
        rf_reg_d   = rf_reg_q;
        rf_oe_d    = 1'b0;
        rf_wr_d    = 1'b0;
        rf_wdata_d = rf_wdata_q;
        rs_val_d   = rs_val_q;
        rt_val_d   = rt_val_q;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;
        rt_addr_d  = rt_addr_q;
        two_d      = two_q;
        case (state_q)
            ST_IDLE: begin
                if (take_wr) begin
                    if (wr_addr == '0) begin
                        // $0 is hardwired: acknowledge without touching the RF
                        wr_done_d = 1'b1;
                    end else begin
                        state_d    = ST_WR;
                        rf_reg_d   = wr_addr;
                        rf_wdata_d = wr_data;
                        rf_wr_d    = 1'b1;
                    end
                end else if (take_rd) begin
                    state_d   = ST_RD_RS;
                    rf_reg_d  = rs_addr;
                    rf_oe_d   = 1'b1;
                    rt_addr_d = rt_addr;
                    two_d     = rd_two;
                end
            end
            ST_RD_RS: begin
                rs_val_d = rf_rdata;
                if (two_q) begin
                    state_d  = ST_RD_RT;
                    rf_reg_d = rt_addr_q;
                    rf_oe_d  = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b1;
                end
            end
            ST_RD_RT: begin
                rt_val_d   = rf_rdata;
                state_d    = ST_IDLE;
                rd_valid_d = 1'b1;
            end
            ST_WR: begin
                state_d   = ST_IDLE;
                wr_done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset also suppresses any capture or
    // done pulse of the operation that was in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rf_reg_q   <= '0;
            rf_oe_q    <= 1'b0;
            rf_wr_q    <= 1'b0;
            rf_wdata_q <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rt_addr_q  <= '0;
            two_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_reg_q   <= rf_reg_d;
            rf_oe_q    <= rf_oe_d;
            rf_wr_q    <= rf_wr_d;
            rf_wdata_q <= rf_wdata_d;
            rs_val_q   <= rs_val_d;
            rt_val_q   <= rt_val_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            rt_addr_q  <= rt_addr_d;
            two_q      <= two_d;
        end
    end

    assign rf_reg   = rf_reg_q;
    assign rf_oe    = rf_oe_q;
    assign rf_wr    = rf_wr_q;
    assign rf_wdata = rf_wdata_q;
    assign rs_val   = rs_val_q;
    assign rt_val   = rt_val_q;
    assign rd_valid = rd_valid_q;
    assign wr_done  = wr_done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rf_port_sequencer.sv
// Directed bench: sequencer beside a behavioural single-port register file
// (write on falling edge, combinational read while OE is high).
module tb_rf_port_sequencer;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_req, rd_two, wr_req;
    logic [AW-1:0] rs_addr, rt_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rs_val, rt_val, rf_wdata, rf_rdata;
    logic          rd_valid, wr_done, busy, rf_oe, rf_wr;
    logic [AW-1:0] rf_reg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_port_sequencer #(.AW(AW), .DW(DW), .WR_PRIORITY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_two(rd_two), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_val(rs_val), .rt_val(rt_val), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .busy(busy), .rf_reg(rf_reg), .rf_oe(rf_oe), .rf_wr(rf_wr),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Register file model; $0 reads as zero, undriven bus reads as garbage
    logic [DW-1:0] rf_mem [32];
    always @(negedge clk) begin
        if (rf_wr) rf_mem[rf_reg] <= rf_wdata;
    end
    assign rf_rdata = rf_oe ? ((rf_reg == '0) ? '0 : rf_mem[rf_reg]) : 32'hDEAD_BEEF;

    // Step cycles from the accept edge until the done pulse (bounded).
    // lat = cycle index at which the pulse is seen, -1 on timeout.
    task automatic run_until(input bit want_wr, output int lat, output int oe_cnt, output int wr_cnt);
        lat = -1; oe_cnt = 0; wr_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (rf_oe) oe_cnt++;
            if (rf_wr) wr_cnt++;
            if (want_wr ? wr_done : rd_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_req = 0; rd_two = 0; wr_req = 0;
        rs_addr = '0; rt_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({rd_valid, wr_done} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {rd_valid, wr_done}); end
        checks++; if ({rf_oe, rf_wr} !== 2'b00) begin errors++; $display("FAIL reset_rf_ctl got %b want 00", {rf_oe, rf_wr}); end
        checks++; if (rf_reg !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL reset_rf_bus got reg=%0d wdata=%h want 0/0", rf_reg, rf_wdata); end
        checks++; if (rs_val !== '0 || rt_val !== '0) begin errors++; $display("FAIL reset_vals got rs=%h rt=%h want 0/0", rs_val, rt_val); end
        $display("reset: busy=%b rf_oe=%b rf_wr=%b", busy, rf_oe, rf_wr);
        rst_n = 1'b1;
    endtask

    task automatic test_write_then_read();
        int lat, oe, wr;
        wr_req = 1; wr_addr = 5'd3; wr_data = 32'h1234_5678;
        run_until(1, lat, oe, wr);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr3_latency got %0d want 2", lat); end
        checks++; if (wr !== 1) begin errors++; $display("FAIL wr3_wr_cycles got %0d want 1", wr); end
        checks++; if (rf_mem[3] !== 32'h1234_5678) begin errors++; $display("FAIL wr3_rf got %h want 12345678", rf_mem[3]); end
        $display("write $3<=%h lat=%0d", wr_data, lat);
        wr_req = 0;
        rd_req = 1; rs_addr = 5'd3; rd_two = 0;
        run_until(0, lat, oe, wr);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd3_latency got %0d want 2", lat); end
        checks++; if (oe !== 1) begin errors++; $display("FAIL rd3_oe_cycles got %0d want 1", oe); end
        checks++; if (rs_val !== 32'h1234_5678) begin errors++; $display("FAIL rd3_rs_val got %h want 12345678", rs_val); end
        $display("read $3 -> %h lat=%0d", rs_val, lat);
        rd_req = 0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_dual_read();
        int lat, oe, wr;
        logic [AW-1:0] addrs [2];
        logic [DW-1:0] vals [2];
        addrs[0] = 5'd4; vals[0] = 32'hA;
        addrs[1] = 5'd5; vals[1] = 32'hB;
        for (int i = 0; i < 2; i++) begin
            wr_req = 1; wr_addr = addrs[i]; wr_data = vals[i];
            run_until(1, lat, oe, wr);
            checks++; if (lat !== 2) begin errors++; $display("FAIL pre_wr%0d_latency got %0d want 2", i, lat); end
            $display("write $%0d<=%h lat=%0d", wr_addr, wr_data, lat);
            wr_req = 0;
            @(posedge clk); @(negedge clk);
        end
        rd_req = 1; rd_two = 1; rs_addr = 5'd4; rt_addr = 5'd5;
        run_until(0, lat, oe, wr);
        checks++; if (lat !== 3) begin errors++; $display("FAIL dual_latency got %0d want 3", lat); end
        checks++; if (oe !== 2) begin errors++; $display("FAIL dual_oe_cycles got %0d want 2", oe); end
        checks++; if (wr !== 0) begin errors++; $display("FAIL dual_rf_wr got %0d want 0", wr); end
        checks++; if (rs_val !== 32'hA || rt_val !== 32'hB) begin errors++; $display("FAIL dual_vals got rs=%h rt=%h want a/b", rs_val, rt_val); end
        $display("dual read $4,$5 -> %h,%h lat=%0d", rs_val, rt_val, lat);
        rd_req = 0; rd_two = 0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int lat, oe, wr;
        wr_req = 1; wr_addr = 5'd4; wr_data = 32'hC;
        rd_req = 1; rd_two = 0; rs_addr = 5'd4;
        run_until(1, lat, oe, wr);
        checks++; if (lat !== 2 || oe !== 0) begin errors++; $display("FAIL sim_write_first got lat=%0d oe=%0d want 2/0", lat, oe); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL sim_rd_early got %b want 0", rd_valid); end
        wr_req = 0;
        run_until(0, lat, oe, wr);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sim_rd_latency got %0d want 2", lat); end
        checks++; if (rs_val !== 32'hC) begin errors++; $display("FAIL sim_rs_val got %h want c", rs_val); end
        $display("simultaneous wr $4<=c / rd $4 -> %h", rs_val);
        rd_req = 0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_write_zero();
        int lat, oe, wr;
        wr_req = 1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        run_until(1, lat, oe, wr);
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr0_latency got %0d want 1", lat); end
        checks++; if (wr !== 0 || busy !== 1'b0) begin errors++; $display("FAIL wr0_rf_wr got wr=%0d busy=%b want 0/0", wr, busy); end
        $display("write $0<=%h lat=%0d", wr_data, lat);
        wr_req = 0;
        @(posedge clk); @(negedge clk);
        checks++; if (rf_wr !== 1'b0 || wr_done !== 1'b0) begin errors++; $display("FAIL wr0_after got rf_wr=%b done=%b want 0/0", rf_wr, wr_done); end
        rd_req = 1; rd_two = 0; rs_addr = 5'd0;
        run_until(0, lat, oe, wr);
        checks++; if (lat !== 2 || rs_val !== '0) begin errors++; $display("FAIL rd0 got lat=%0d rs=%h want 2/0", lat, rs_val); end
        checks++; if (rt_val !== 32'hB) begin errors++; $display("FAIL rd0_rt_kept got %h want b", rt_val); end
        $display("read $0 -> %h", rs_val);
        rd_req = 0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_req_held();
        int lat, oe, wr;
        rd_req = 1; rd_two = 0; rs_addr = 5'd3;
        run_until(0, lat, oe, wr);
        checks++; if (lat !== 2 || rs_val !== 32'h1234_5678) begin errors++; $display("FAIL held_read got lat=%0d rs=%h want 2/12345678", lat, rs_val); end
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0 || rf_oe !== 1'b0) begin errors++; $display("FAIL held_no_restart got busy=%b oe=%b want 0/0", busy, rf_oe); end
        rd_req = 0;
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL held_idle got busy=%b valid=%b want 0/0", busy, rd_valid); end
        $display("held rd_req through rd_valid: busy=%b", busy);
    endtask

    task automatic test_reset_during_read();
        rd_req = 1; rd_two = 1; rs_addr = 5'd4; rt_addr = 5'd5;
        @(posedge clk); @(negedge clk);
        checks++; if (rf_oe !== 1'b1) begin errors++; $display("FAIL rstrd_oe got %b want 1", rf_oe); end
        rst_n = 0;
        @(posedge clk); @(negedge clk);
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || rf_oe !== 1'b0) begin errors++; $display("FAIL rstrd_ctl got valid=%b busy=%b oe=%b want 0/0/0", rd_valid, busy, rf_oe); end
        checks++; if (rs_val !== '0 || rt_val !== '0) begin errors++; $display("FAIL rstrd_vals got rs=%h rt=%h want 0/0", rs_val, rt_val); end
        $display("reset during read: rs=%h rt=%h", rs_val, rt_val);
        rst_n = 1; rd_req = 0; rd_two = 0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_during_write();
        wr_req = 1; wr_addr = 5'd7; wr_data = 32'h55;
        @(posedge clk); @(negedge clk);
        checks++; if (rf_wr !== 1'b1) begin errors++; $display("FAIL rstwr_wr got %b want 1", rf_wr); end
        rst_n = 0;
        @(posedge clk); @(negedge clk);
        checks++; if (rf_mem[7] !== 32'h55) begin errors++; $display("FAIL rstwr_rf got %h want 55", rf_mem[7]); end
        checks++; if (wr_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstwr_done got done=%b busy=%b want 0/0", wr_done, busy); end
        checks++; if (rf_wr !== 1'b0 || rf_reg !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL rstwr_rf_bus got wr=%b reg=%0d wdata=%h want 0/0/0", rf_wr, rf_reg, rf_wdata); end
        $display("reset during write $7: rf=%h done=%b", rf_mem[7], wr_done);
        rst_n = 1; wr_req = 0;
        @(posedge clk); @(negedge clk);
        checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL rstwr_late_done got %b want 0", wr_done); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_then_read();
        test_dual_read();
        test_simultaneous();
        test_write_zero();
        test_req_held();
        test_reset_during_read();
        test_reset_during_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
